// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register file's single write port between the pipeline
//   writeback (PIPE) and the multi-cycle MUL/DIV unit (MDU). MDU results are
//   buffered in a small FIFO. A per-register busy scoreboard tracks in-flight
//   MDU destinations so decode can stall on RAW hazards.
//
// Port summary
//   clk_i, rst_n_i                      clock, async active-low reset
//   pipe_we_i/pipe_rd_i/pipe_data_i     pipeline writeback request
//   mdu_valid_i/mdu_ready_o             MDU result handshake
//   mdu_rd_i/mdu_data_i                 MDU result destination/data
//   issue_valid_i/issue_rd_i            MDU op issue (sets busy)
//   rs1_addr_i/rs2_addr_i               decode sources
//   rs1_busy_o/rs2_busy_o               busy lookup (combinational, 0 for x0)
//   pipe_stall_o                        WB slot forced to the FIFO this cycle
//   write_en_o/in_addr_o/data_in_o      registered register file write port
//
// Configuration
//   WB_BYPASS_EN  when defined, an MDU result arriving on an idle port with
//                 an empty FIFO is written straight to the outputs.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_rd_i,
    input  logic [31:0] pipe_data_i,
    input  logic        mdu_valid_i,
    output logic        mdu_ready_o,
    input  logic [4:0]  mdu_rd_i,
    input  logic [31:0] mdu_data_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    output logic        pipe_stall_o,
    output logic        write_en_o,
    output logic [4:0]  in_addr_o,
    output logic [31:0] data_in_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          we_q, we_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   busy_q, busy_d;

    logic fifo_empty, fifo_full, pipe_req, pop, push, bypass, clr_busy;
    logic [4:0] clr_addr;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FULL_CNT);
    assign mdu_ready_o = rst_n_i & ~fifo_full;
    assign pipe_req    = pipe_we_i & (pipe_rd_i != 5'd0);

`ifdef WB_BYPASS_EN
    assign bypass = fifo_empty & ~stall_q & ~pipe_req & mdu_valid_i & (mdu_rd_i != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // A full FIFO never pushes: ready is evaluated on the pre-edge occupancy.
    assign push = mdu_valid_i & ~fifo_full & (mdu_rd_i != 5'd0) & ~bypass;

    always_comb begin
        pop      = 1'b0;
        stall_d  = 1'b0;
        starve_d = '0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        clr_busy = 1'b0;
        clr_addr = 5'd0;

        if (stall_q) begin
            // Forced slot; the pipe holds its request and re-presents it.
            pop = ~fifo_empty;
        end else if (pipe_req) begin
            we_d   = 1'b1;
            addr_d = pipe_rd_i;
            data_d = pipe_data_i;
            if (!fifo_empty) begin
                if (starve_q == STARVE_LAST) stall_d = 1'b1;
                else                         starve_d = starve_q + 1'b1;
            end
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end else if (bypass) begin
            we_d     = 1'b1;
            addr_d   = mdu_rd_i;
            data_d   = mdu_data_i;
            clr_busy = 1'b1;
            clr_addr = mdu_rd_i;
        end

        if (pop) begin
            we_d     = 1'b1;
            addr_d   = fifo_rd_q[rptr_q];
            data_d   = fifo_data_q[rptr_q];
            clr_busy = 1'b1;
            clr_addr = fifo_rd_q[rptr_q];
        end

        rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear first so a same-cycle reissue of the register wins.
        busy_d = busy_q;
        if (clr_busy) busy_d[clr_addr] = 1'b0;
        if (issue_valid_i && issue_rd_i != 5'd0) busy_d[issue_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 5'd0;
            data_q   <= 32'd0;
            busy_q   <= 32'd0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= mdu_rd_i;
            fifo_data_q[wptr_q] <= mdu_data_i;
        end
    end

    assign rs1_busy_o   = (rs1_addr_i != 5'd0) & busy_q[rs1_addr_i];
    assign rs2_busy_o   = (rs2_addr_i != 5'd0) & busy_q[rs2_addr_i];
    assign pipe_stall_o = stall_q;
    assign write_en_o   = we_q;
    assign in_addr_o    = addr_q;
    assign data_in_o    = data_q;

endmodule
